// File: rtl/pacoblaze_sequencer.sv
// pacoblaze_sequencer
// Program sequencer for the PacoBlaze core. It holds the program counter, the
// call/return stack and the interrupt-enable state. It fetches the instruction
// word for the decode unit and computes the next program address from the
// decoded operation and branch fields. Each instruction takes two clocks:
// T0 fetch, then T1 execute.
//
// Optional build macro: PACOBLAZE_STACK_CHECK_EN
//   defined   -> adds sticky stack_overflow / stack_underflow outputs, driven
//                by a stack occupancy counter
//   undefined -> those ports are absent and the stack pointer simply wraps
//
// state | meaning
// ------+------------------------------------------------------------------
// T0    | fetch: address = pc; rom_data is latched into instruction on exit
// T1    | execute: execute = 1; pc, sp, stack and ie are updated on exit

module pacoblaze_sequencer #(
    parameter int CODE_DEPTH      = 10,
    parameter int STACK_DEPTH     = 31,
    parameter int operation_width = 5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    output logic [CODE_DEPTH-1:0]      address,
    input  logic [17:0]                rom_data,
    output logic [17:0]                instruction,
    output logic                       execute,
    input  logic [operation_width-1:0] operation,
    input  logic                       conditional,
    input  logic [1:0]                 condition_flags,
    input  logic [CODE_DEPTH-1:0]      code_address,
    input  logic                       interrupt_enable,
    input  logic                       zero,
    input  logic                       carry,
    input  logic                       interrupt,
    output logic                       interrupt_ack,
    output logic                       flags_save,
    output logic                       flags_restore,
    output logic                       ie
`ifdef PACOBLAZE_STACK_CHECK_EN
    ,
    output logic                       stack_overflow,
    output logic                       stack_underflow
`endif
);

    // Shared operation encoding; only the codes that affect sequencing are
    // listed, every other code simply advances the pc.
    localparam logic [operation_width-1:0] op_jump      = operation_width'(1);
    localparam logic [operation_width-1:0] op_call      = operation_width'(2);
    localparam logic [operation_width-1:0] op_return    = operation_width'(3);
    localparam logic [operation_width-1:0] op_returni   = operation_width'(4);
    localparam logic [operation_width-1:0] op_interrupt = operation_width'(5);

    localparam logic [0:0] st_t0 = 1'b0;
    localparam logic [0:0] st_t1 = 1'b1;

    localparam int sp_width = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [sp_width-1:0]   sp_last    = sp_width'(STACK_DEPTH - 1);
    localparam logic [CODE_DEPTH-1:0] irq_vector = '1;

    // The stack pointer wraps modulo STACK_DEPTH, which need not be a power
    // of two, so plain binary overflow is not enough.
    function automatic logic [sp_width-1:0] sp_inc(input logic [sp_width-1:0] v);
        return (v == sp_last) ? '0 : v + sp_width'(1);
    endfunction

    function automatic logic [sp_width-1:0] sp_dec(input logic [sp_width-1:0] v);
        return (v == '0) ? sp_last : v - sp_width'(1);
    endfunction

    logic [0:0]            state;
    logic [CODE_DEPTH-1:0] pc;
    logic [sp_width-1:0]   sp;
    logic                  ie_q;
    logic                  ack_q;
    logic [CODE_DEPTH-1:0] stack [STACK_DEPTH];

    logic                  in_t1;
    logic                  cond_met;
    logic                  take;
    logic [CODE_DEPTH-1:0] pc_inc;
    logic                  do_call;
    logic                  do_pop;
    logic                  irq_take;
    logic                  ie_write;
    logic [CODE_DEPTH-1:0] popped;
    logic [CODE_DEPTH-1:0] branch_pc;
    logic [CODE_DEPTH-1:0] next_pc;
    logic [sp_width-1:0]   sp_after_pop;
    logic [sp_width-1:0]   irq_slot;
    logic [sp_width-1:0]   sp_next;

    // Branch condition evaluation and next-address selection for T1.
    always_comb begin
        in_t1 = (state == st_t1);

        case (condition_flags)
            2'b00:   cond_met = zero;
            2'b01:   cond_met = ~zero;
            2'b10:   cond_met = carry;
            default: cond_met = ~carry;
        endcase
        take = ~conditional | cond_met;

        pc_inc   = pc + CODE_DEPTH'(1);
        do_call  = in_t1 && (operation == op_call) && take;
        do_pop   = in_t1 && (((operation == op_return) && take) ||
                             (operation == op_returni));
        ie_write = in_t1 && ((operation == op_returni) ||
                             (operation == op_interrupt));
        // The ie value held before this edge decides, so an instruction that
        // enables interrupts cannot be interrupted itself.
        irq_take = in_t1 && ie_q && interrupt;

        popped = stack[sp_dec(sp)];

        branch_pc = pc_inc;
        case (operation)
            op_jump:    if (take) branch_pc = code_address;
            op_call:    if (take) branch_pc = code_address;
            op_return:  if (take) branch_pc = popped;
            op_returni: branch_pc = popped;
            default:    branch_pc = pc_inc;
        endcase

        next_pc = irq_take ? irq_vector : branch_pc;

        // A pop frees the slot first; a call pushes next; an accepted
        // interrupt pushes the resolved branch result after that.
        sp_after_pop = do_pop ? sp_dec(sp) : sp;
        irq_slot     = do_call ? sp_inc(sp) : sp_after_pop;
        sp_next      = sp_after_pop;
        if (do_call) begin
            sp_next = sp_inc(sp_next);
        end
        if (irq_take) begin
            sp_next = sp_inc(sp_next);
        end
    end

    // Return-address storage; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (do_call) begin
                stack[sp] <= pc_inc;
            end
            if (irq_take) begin
                stack[irq_slot] <= branch_pc;
            end
        end
    end

    // Two-phase instruction cycle, program counter and interrupt state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= st_t0;
            pc          <= '0;
            sp          <= '0;
            ie_q        <= 1'b0;
            ack_q       <= 1'b0;
            instruction <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                st_t0: begin
                    instruction <= rom_data;
                    state       <= st_t1;
                end
                default: begin
                    pc    <= next_pc;
                    sp    <= sp_next;
                    ack_q <= irq_take;
                    if (irq_take) begin
                        ie_q <= 1'b0;
                    end else if (ie_write) begin
                        ie_q <= interrupt_enable;
                    end
                    state <= st_t0;
                end
            endcase
        end
    end

    assign address       = pc;
    assign execute       = in_t1;
    assign ie            = ie_q;
    assign interrupt_ack = ack_q;
    assign flags_save    = irq_take;
    assign flags_restore = in_t1 && (operation == op_returni);

`ifdef PACOBLAZE_STACK_CHECK_EN
    logic [sp_width:0] depth_used;
    logic [sp_width:0] depth_next;
    logic              overflow_evt;
    logic              underflow_evt;

    // Occupancy tracking: saturates at full and at empty, flagging pushes
    // onto a full stack and pops from an empty one.
    always_comb begin
        depth_next    = depth_used;
        overflow_evt  = 1'b0;
        underflow_evt = 1'b0;
        if (do_pop) begin
            if (depth_next == '0) begin
                underflow_evt = 1'b1;
            end else begin
                depth_next = depth_next - (sp_width + 1)'(1);
            end
        end
        if (do_call) begin
            if (depth_next == (sp_width + 1)'(STACK_DEPTH)) begin
                overflow_evt = 1'b1;
            end else begin
                depth_next = depth_next + (sp_width + 1)'(1);
            end
        end
        if (irq_take) begin
            if (depth_next == (sp_width + 1)'(STACK_DEPTH)) begin
                overflow_evt = 1'b1;
            end else begin
                depth_next = depth_next + (sp_width + 1)'(1);
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            depth_used      <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            depth_used <= depth_next;
            if (overflow_evt) begin
                stack_overflow <= 1'b1;
            end
            if (underflow_evt) begin
                stack_underflow <= 1'b1;
            end
        end
    end
`endif

endmodule
